// File: rtl/btn_event_queue_pkg.sv
// Shared event-word layout and message identifiers for the button event front end.
package btn_event_queue_pkg;

   localparam int EVT_W        = 28;
   localparam int EVT_CH_MSB   = 27;
   localparam int EVT_CH_LSB   = 24;
   localparam int EVT_EDGE_BIT = 23;

   localparam logic [7:0] MSG_ID_BTN_EVENT = 8'h21;
   localparam logic [7:0] MSG_ID_BTN_STATE = 8'h22;

   // Bits between the edge flag and the timestamp stay zero because ts arrives zero-extended.
   function automatic logic [EVT_W-1:0] packEvent(input logic [3:0]            ch,
                                                   input logic                  pressed,
                                                   input logic [EVT_EDGE_BIT-1:0] ts);
      logic [EVT_W-1:0] w;
      w = '0;
      w[EVT_CH_MSB:EVT_CH_LSB] = ch;
      w[EVT_EDGE_BIT]          = pressed;
      w[EVT_EDGE_BIT-1:0]      = ts;
      return w;
   endfunction

endpackage

// File: rtl/btn_event_queue_sync_fifo.sv
// First-word fall-through FIFO with exact occupancy count and a drop strobe when a write
// finds it full without a simultaneous pop.
module sync_fifo #(
   parameter int WIDTH = 28,
   parameter int DEPTH = 8
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     wr_en_i,
   input  logic [WIDTH-1:0]         wr_data_i,
   input  logic                     rd_en_i,
   output logic [WIDTH-1:0]         rd_data_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     wr_drop_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             full, pop, push;

   always_comb begin
      full      = (count_q == (AW+1)'(DEPTH));
      pop       = rd_en_i && (count_q != '0);
      push      = wr_en_i && (!full || pop);
      wr_drop_o = wr_en_i && !push;
      wr_ptr_d  = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d  = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d   = count_q;
      if (push && !pop) begin
         count_d = count_q + 1'b1;
      end else if (pop && !push) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) begin
         mem_q[wr_ptr_q] <= wr_data_i;
      end
   end

   // Head is forced to zero when empty so the output is clean after reset.
   assign rd_data_o = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
   assign empty_o   = (count_q == '0);
   assign count_o   = count_q;

endmodule

// File: rtl/btn_event_queue.sv
// N-channel button front end: 2-FF sync, debounce, timestamp, and press/release events
// serialised by channel priority into a FIFO with sticky overflow.
module btn_event_queue
   import btn_event_queue_pkg::*;
#(
   parameter int N_CH         = 4,
   parameter int ACTIVE_LOW   = 1,
   parameter int DEBOUNCE_CYC = 1000,
   parameter int FIFO_DEPTH   = 8,
   parameter int TS_W         = 16,
   parameter int TICK_DIV     = 1000
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic [N_CH-1:0]               btn_in_i,
   output logic [N_CH-1:0]               btn_state_o,
   output logic                          evt_valid_o,
   output logic [EVT_W-1:0]              evt_data_o,
   input  logic                          evt_ready_i,
   output logic [$clog2(FIFO_DEPTH):0]   evt_count_o,
   output logic                          overflow_o,
   input  logic                          ovf_clr_i
);

   localparam int CW = $clog2(DEBOUNCE_CYC + 1);
   localparam int DW = $clog2(TICK_DIV + 1);

   logic [TS_W-1:0]         ts_q, ts_d;
   logic [DW-1:0]           div_q, div_d;
   logic [N_CH-1:0]         pend_vec, press_vec, grant;
   logic [TS_W-1:0]         ts_lat [N_CH];
   logic                    wr_en, wr_drop, fifo_empty, sel_press;
   logic [3:0]              grant_idx;
   logic [TS_W-1:0]         sel_ts;
   logic [EVT_W-1:0]        wr_word;
   logic                    ovf_q, ovf_d;

   always_comb begin
      div_d = div_q + 1'b1;
      ts_d  = ts_q;
      if (div_q == DW'(TICK_DIV - 1)) begin
         div_d = '0;
         ts_d  = ts_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         div_q <= '0;
         ts_q  <= '0;
      end else begin
         div_q <= div_d;
         ts_q  <= ts_d;
      end
   end

   genvar g;
   for (g = 0; g < N_CH; g++) begin : g_ch
      logic          sync1_q, sync2_q, state_q, pend_q, press_q, lvl;
      logic [CW-1:0] cnt_q;
      logic [TS_W-1:0] ts_lat_q;

      assign lvl = (ACTIVE_LOW != 0) ? ~sync2_q : sync2_q;

      // Completion is the DEBOUNCE_CYC-th consecutive edge on which lvl differs from state.
      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            state_q  <= 1'b0;
            pend_q   <= 1'b0;
            press_q  <= 1'b0;
            cnt_q    <= '0;
            ts_lat_q <= '0;
         end else begin
            sync1_q <= btn_in_i[g];
            sync2_q <= sync1_q;
            if (grant[g]) begin
               pend_q <= 1'b0;
            end
            if (lvl != state_q) begin
               if (cnt_q == CW'(DEBOUNCE_CYC - 1)) begin
                  state_q  <= lvl;
                  cnt_q    <= '0;
                  pend_q   <= 1'b1;
                  press_q  <= lvl;
                  ts_lat_q <= ts_q;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end else begin
               cnt_q <= '0;
            end
         end
      end

      assign btn_state_o[g] = state_q;
      assign pend_vec[g]    = pend_q;
      assign press_vec[g]   = press_q;
      assign ts_lat[g]      = ts_lat_q;
   end

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      sel_press = 1'b0;
      sel_ts    = '0;
      for (int i = N_CH - 1; i >= 0; i--) begin
         if (pend_vec[i]) begin
            grant     = '0;
            grant[i]  = 1'b1;
            grant_idx = 4'(i);
            sel_press = press_vec[i];
            sel_ts    = ts_lat[i];
         end
      end
      wr_en   = |pend_vec;
      wr_word = packEvent(grant_idx, sel_press, EVT_EDGE_BIT'(sel_ts));
   end

   sync_fifo #(
      .WIDTH (EVT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .wr_en_i   (wr_en),
      .wr_data_i (wr_word),
      .rd_en_i   (evt_ready_i),
      .rd_data_o (evt_data_o),
      .empty_o   (fifo_empty),
      .count_o   (evt_count_o),
      .wr_drop_o (wr_drop)
   );

   // A drop in the same cycle as a clear still leaves the flag set.
   always_comb begin
      ovf_d = ovf_q;
      if (wr_drop) begin
         ovf_d = 1'b1;
      end else if (ovf_clr_i) begin
         ovf_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ovf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
      end
   end

   assign overflow_o  = ovf_q;
   assign evt_valid_o = !fifo_empty;

endmodule

// File: tb/tb_btn_event_queue.sv
// Self-checking bench: table vectors, hand-written corner sequences, and random stimulus
// compared every cycle against a queue-based reference model.
module tb_btn_event_queue;

   localparam int NCH   = 4;
   localparam int DEB   = 8;
   localparam int DEPTH = 4;
   localparam int TSW   = 16;
   localparam int TDIV  = 1;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  btnIn;
   logic        evtReady;
   logic        ovfClr;
   logic [3:0]  btnState;
   logic        evtValid;
   logic [27:0] evtData;
   logic [2:0]  evtCount;
   logic        overflow;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   btn_event_queue #(
      .N_CH         (NCH),
      .ACTIVE_LOW   (1),
      .DEBOUNCE_CYC (DEB),
      .FIFO_DEPTH   (DEPTH),
      .TS_W         (TSW),
      .TICK_DIV     (TDIV)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .btn_in_i    (btnIn),
      .btn_state_o (btnState),
      .evt_valid_o (evtValid),
      .evt_data_o  (evtData),
      .evt_ready_i (evtReady),
      .evt_count_o (evtCount),
      .overflow_o  (overflow),
      .ovf_clr_i   (ovfClr)
   );

   // Reference model: pin seen two edges late, run lengths, pending events, queue FIFO.
   logic [3:0]  mPin1, mPin2, mState, mPend;
   int          mRun [4];
   logic [27:0] mPendWord [4];
   logic [27:0] mFifo [$];
   logic        mOvf;
   int          mCyc;

   task automatic modelEdge(input logic [3:0] btn, input logic rdy, input logic clr,
                            input logic rs);
      logic [3:0] lvl;
      logic       popNow;
      int         g;
      int         preSize;
      if (rs) begin
         mPin1 = '0; mPin2 = '0; mState = '0; mPend = '0; mOvf = 1'b0; mCyc = 0;
         for (int c = 0; c < 4; c++) begin
            mRun[c] = 0; mPendWord[c] = '0;
         end
         mFifo.delete();
         return;
      end
      lvl     = ~mPin2;
      preSize = mFifo.size();
      popNow  = rdy && (preSize > 0);
      g = -1;
      for (int c = 0; c < 4; c++) if (mPend[c] && g < 0) g = c;
      if (popNow) void'(mFifo.pop_front());
      if (g >= 0) begin
         if (preSize < DEPTH || popNow) mFifo.push_back(mPendWord[g]);
         else mOvf = 1'b1;
         mPend[g] = 1'b0;
      end else if (clr) begin
         mOvf = 1'b0;
      end
      if (g >= 0 && clr && (preSize < DEPTH || popNow)) mOvf = 1'b0;
      for (int c = 0; c < 4; c++) begin
         if (lvl[c] != mState[c]) begin
            mRun[c]++;
            if (mRun[c] == DEB) begin
               mState[c]     = lvl[c];
               mRun[c]       = 0;
               mPend[c]      = 1'b1;
               mPendWord[c]  = {4'(c), lvl[c], 7'b0, 16'((mCyc / TDIV) % 65536)};
            end
         end else begin
            mRun[c] = 0;
         end
      end
      mCyc++;
      mPin2 = mPin1;
      mPin1 = btn;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic checkModel();
      checkOutput("model btn_state", 32'(btnState), 32'(mState));
      checkOutput("model evt_valid", 32'(evtValid), 32'(mFifo.size() > 0));
      checkOutput("model evt_data", 32'(evtData), (mFifo.size() > 0) ? 32'(mFifo[0]) : 32'h0);
      checkOutput("model evt_count", 32'(evtCount), 32'(mFifo.size()));
      checkOutput("model overflow", 32'(overflow), 32'(mOvf));
   endtask

   task automatic applyStimulus(input logic [3:0] btn, input logic rdy, input logic clr,
                                input logic rs);
      btnIn    = btn;
      evtReady = rdy;
      ovfClr   = clr;
      rst      = rs;
      @(posedge clk);
      modelEdge(btn, rdy, clr, rs);
      @(negedge clk);
      checkModel();
   endtask

   task automatic holdFor(input logic [3:0] btn, input logic rdy, input int n);
      for (int k = 0; k < n; k++) applyStimulus(btn, rdy, 1'b0, 1'b0);
   endtask

   typedef struct {
      logic [3:0] btn;
      logic       rdy;
      int         cycles;
      logic       expValid;
      logic [4:0] expHead;
      logic [3:0] expState;
      int         expCount;
   } vec_t;

   vec_t       vecs [$];
   logic [15:0] tsFirst;
   logic [3:0]  rndBtn;

   initial begin
      btnIn = 4'hF; evtReady = 1'b0; ovfClr = 1'b0; rst = 1'b1;
      applyStimulus(4'hF, 1'b0, 1'b0, 1'b1);
      applyStimulus(4'hF, 1'b0, 1'b0, 1'b1);
      checkOutput("reset evt_valid", 32'(evtValid), 32'h0);
      checkOutput("reset evt_data", 32'(evtData), 32'h0);
      checkOutput("reset btn_state", 32'(btnState), 32'h0);
      checkOutput("reset overflow", 32'(overflow), 32'h0);

      // Single press/release on ch0, then a 7-cycle glitch on ch2.
      vecs.push_back('{4'hF, 1'b0, 12, 1'b0, 5'b00000, 4'b0000, 0});
      vecs.push_back('{4'hE, 1'b0, 10, 1'b0, 5'b00000, 4'b0001, 0});
      vecs.push_back('{4'hE, 1'b0,  1, 1'b1, 5'b00001, 4'b0001, 1});
      vecs.push_back('{4'hE, 1'b0,  9, 1'b1, 5'b00001, 4'b0001, 1});
      vecs.push_back('{4'hF, 1'b1, 11, 1'b1, 5'b00000, 4'b0000, 1});
      vecs.push_back('{4'hF, 1'b1,  1, 1'b0, 5'b00000, 4'b0000, 0});
      vecs.push_back('{4'hB, 1'b0,  7, 1'b0, 5'b00000, 4'b0000, 0});
      vecs.push_back('{4'hF, 1'b0, 12, 1'b0, 5'b00000, 4'b0000, 0});
      for (int v = 0; v < vecs.size(); v++) begin
         holdFor(vecs[v].btn, vecs[v].rdy, vecs[v].cycles);
         checkOutput("vec evt_valid", 32'(evtValid), 32'(vecs[v].expValid));
         checkOutput("vec btn_state", 32'(btnState), 32'(vecs[v].expState));
         checkOutput("vec evt_count", 32'(evtCount), 32'(vecs[v].expCount));
         if (vecs[v].expValid) checkOutput("vec head", 32'(evtData[27:23]), 32'(vecs[v].expHead));
      end

      // Simultaneous ch1/ch3 presses serialise in channel order with equal timestamps.
      holdFor(4'b0101, 1'b0, 11);
      checkOutput("simul first count", 32'(evtCount), 32'd1);
      checkOutput("simul first head", 32'(evtData[27:23]), 32'b00011);
      tsFirst = evtData[15:0];
      holdFor(4'b0101, 1'b0, 1);
      checkOutput("simul second count", 32'(evtCount), 32'd2);
      holdFor(4'b0101, 1'b1, 1);
      checkOutput("simul second head", 32'(evtData[27:23]), 32'b00111);
      checkOutput("simul equal ts", 32'(evtData[15:0]), 32'(tsFirst));
      holdFor(4'b0101, 1'b1, 1);
      holdFor(4'hF, 1'b1, 14);
      checkOutput("simul drained", 32'(evtCount), 32'd0);

      // Five events with no pops: four kept, fifth dropped, then cleared.
      holdFor(4'b0000, 1'b0, 14);
      checkOutput("fill count", 32'(evtCount), 32'd4);
      checkOutput("fill overflow", 32'(overflow), 32'd0);
      holdFor(4'b0001, 1'b0, 11);
      checkOutput("ovf count", 32'(evtCount), 32'd4);
      checkOutput("ovf flag", 32'(overflow), 32'd1);
      checkOutput("ovf head", 32'(evtData[27:23]), 32'b00001);
      applyStimulus(4'b0001, 1'b0, 1'b1, 1'b0);
      checkOutput("ovf cleared", 32'(overflow), 32'd0);

      // Full FIFO: pop coincides with a new write.
      holdFor(4'b0011, 1'b0, 10);
      holdFor(4'b0011, 1'b1, 1);
      checkOutput("fullpop count", 32'(evtCount), 32'd4);
      checkOutput("fullpop overflow", 32'(overflow), 32'd0);
      checkOutput("fullpop head", 32'(evtData[27:23]), 32'b00011);
      holdFor(4'b0011, 1'b1, 3);
      checkOutput("fullpop tail", 32'(evtData[27:23]), 32'b00010);
      checkOutput("fullpop tail count", 32'(evtCount), 32'd1);
      holdFor(4'b0011, 1'b1, 1);

      // Reset mid-debounce with two events queued.
      holdFor(4'hF, 1'b0, 12);
      checkOutput("prereset count", 32'(evtCount), 32'd2);
      holdFor(4'hE, 1'b0, 5);
      applyStimulus(4'hF, 1'b0, 1'b0, 1'b1);
      checkOutput("midreset valid", 32'(evtValid), 32'd0);
      checkOutput("midreset data", 32'(evtData), 32'd0);
      checkOutput("midreset count", 32'(evtCount), 32'd0);
      checkOutput("midreset state", 32'(btnState), 32'd0);
      holdFor(4'hF, 1'b0, 20);
      checkOutput("postreset count", 32'(evtCount), 32'd0);

      // Randomised traffic against the reference model.
      rndBtn = 4'hF;
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 5) == 0) rndBtn[$urandom_range(0, 3)] ^= 1'b1;
         applyStimulus(rndBtn,
                       (n % 600 < 300) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 2) != 0),
                       ($urandom_range(0, 19) == 0),
                       ($urandom_range(0, 599) == 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
